// File: rtl/fpu_arbiter_if.sv
// Requester-side bus of the shared-FPU arbiter: per-requester request fields,
// capture ack, and the broadcast response.
interface fpu_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][2:0]  req_op;
    logic [NREQ-1:0][1:0]  req_rmode;
    logic [NREQ-1:0][63:0] req_opa;
    logic [NREQ-1:0][63:0] req_opb;
    logic [NREQ-1:0]       req_ack;
    logic [NREQ-1:0]       rsp_valid;
    logic [63:0]           rsp_out;

    modport master (
        output req_valid, req_op, req_rmode, req_opa, req_opb,
        input  req_ack, rsp_valid, rsp_out
    );

    modport slave (
        input  req_valid, req_op, req_rmode, req_opa, req_opb,
        output req_ack, rsp_valid, rsp_out
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one double-precision FPU between NREQ requesters, one op in flight.
// Optional macro FPU_ARB_FLAGS_EN adds FPU status flag inputs and a captured o_rsp_flags output.
module fpu_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fpu_arbiter_if.slave  bus,
    output logic          o_busy,
    output logic          o_fpu_enable,
    output logic [2:0]    o_fpu_op,
    output logic [1:0]    o_fpu_rmode,
    output logic [63:0]   o_fpu_opa,
    output logic [63:0]   o_fpu_opb,
    input  logic [63:0]   i_fpu_out,
    input  logic          i_fpu_ready
`ifdef FPU_ARB_FLAGS_EN
    ,
    input  logic          i_fpu_underflow,
    input  logic          i_fpu_overflow,
    input  logic          i_fpu_inexact,
    input  logic          i_fpu_exception,
    input  logic          i_fpu_invalid,
    output logic [4:0]    o_rsp_flags
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, r_gnt, w_gnt_idx;
    logic            w_gnt_found, w_grant, w_done;
    logic [NREQ-1:0] r_ack, r_rsp_valid;
    logic [63:0]     r_rsp_out, r_opa, r_opb;
    logic [2:0]      r_op;
    logic [1:0]      r_rmode;
    logic            r_en;
`ifdef FPU_ARB_FLAGS_EN
    logic [4:0]      r_flags;
`endif

    // Scan from highest rotation offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[IW'((int'(r_ptr) + k) % NREQ)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_found) w_state_nxt = S_RUN;
            S_RUN:   if (i_fpu_ready) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant = 1'b0;
        w_done  = 1'b0;
        o_busy  = 1'b1;
        case (r_state)
            S_IDLE:  begin w_grant = w_gnt_found; o_busy = 1'b0; end
            S_RUN:   w_done = i_fpu_ready;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rsp_valid <= '0;
            r_rsp_out   <= '0;
            r_en        <= 1'b0;
            r_op        <= '0;
            r_rmode     <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
`ifdef FPU_ARB_FLAGS_EN
            r_flags     <= '0;
`endif
        end else begin
            r_ack       <= '0;
            r_rsp_valid <= '0;
            if (w_grant) begin
                r_gnt            <= w_gnt_idx;
                r_ptr            <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                r_ack[w_gnt_idx] <= 1'b1;
                r_en             <= 1'b1;
                r_op             <= bus.req_op[w_gnt_idx];
                r_rmode          <= bus.req_rmode[w_gnt_idx];
                r_opa            <= bus.req_opa[w_gnt_idx];
                r_opb            <= bus.req_opb[w_gnt_idx];
            end
            // Dropping enable here gives the FPU a low cycle in S_DONE to clear its counters.
            if (w_done) begin
                r_rsp_out          <= i_fpu_out;
                r_rsp_valid[r_gnt] <= 1'b1;
                r_en               <= 1'b0;
`ifdef FPU_ARB_FLAGS_EN
                r_flags <= {i_fpu_invalid, i_fpu_exception, i_fpu_inexact,
                            i_fpu_overflow, i_fpu_underflow};
`endif
            end
        end
    end

    assign bus.req_ack   = r_ack;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_out   = r_rsp_out;
    assign o_fpu_enable  = r_en;
    assign o_fpu_op      = r_op;
    assign o_fpu_rmode   = r_rmode;
    assign o_fpu_opa     = r_opa;
    assign o_fpu_opb     = r_opb;
`ifdef FPU_ARB_FLAGS_EN
    assign o_rsp_flags   = r_flags;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a behavioural FPU (fixed latency) and a response scoreboard.
module tb_fpu_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_arbiter_if #(.NREQ(NREQ)) bus();

    logic        busy, fpu_enable, fpu_ready;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [63:0] fpu_opa, fpu_opb, fpu_out;
`ifdef FPU_ARB_FLAGS_EN
    logic        fpu_underflow, fpu_overflow, fpu_inexact, fpu_exception, fpu_invalid;
    logic [4:0]  rsp_flags;
`endif

    fpu_arbiter #(.NREQ(NREQ), .IW(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_busy(busy), .o_fpu_enable(fpu_enable), .o_fpu_op(fpu_op),
        .o_fpu_rmode(fpu_rmode), .o_fpu_opa(fpu_opa), .o_fpu_opb(fpu_opb),
        .i_fpu_out(fpu_out), .i_fpu_ready(fpu_ready)
`ifdef FPU_ARB_FLAGS_EN
        , .i_fpu_underflow(fpu_underflow), .i_fpu_overflow(fpu_overflow),
        .i_fpu_inexact(fpu_inexact), .i_fpu_exception(fpu_exception),
        .i_fpu_invalid(fpu_invalid), .o_rsp_flags(rsp_flags)
`endif
    );

    // Behavioural FPU: ready after LAT enabled cycles, counter cleared while enable is low.
    int fcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          fcnt <= 0;
        else if (fpu_enable) fcnt <= fcnt + 1;
        else                 fcnt <= 0;
    end
    assign fpu_ready = fpu_enable && (fcnt >= LAT);
    always_comb begin
        case (fpu_op)
            3'b010:  fpu_out = $realtobits($bitstoreal(fpu_opa) * $bitstoreal(fpu_opb));
            3'b011:  fpu_out = $realtobits($bitstoreal(fpu_opa) / $bitstoreal(fpu_opb));
            default: fpu_out = $realtobits($bitstoreal(fpu_opa) + $bitstoreal(fpu_opb));
        endcase
    end
`ifdef FPU_ARB_FLAGS_EN
    assign fpu_exception = (fpu_op == 3'b011) && (fpu_opb == 64'd0);
    assign fpu_underflow = 1'b0;
    assign fpu_overflow  = 1'b0;
    assign fpu_inexact   = 1'b0;
    assign fpu_invalid   = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [63:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   ack_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ack = 0;
    int   n_rsp = 0;

    logic [NREQ-1:0] mon_ack, mon_v;
    logic [63:0]     mon_d;
    rsp_t            mon_e;

    always @(negedge clk) begin
        if (rst_n && bus.req_ack != '0) begin
            mon_ack = '0;
            if (ack_q.size() > 0) mon_ack = NREQ'(1) << ack_q.pop_front();
            checks++;
            assert (bus.req_ack === mon_ack) else begin
                errors++; $error("FAIL ack_order got %b exp %b", bus.req_ack, mon_ack);
            end
            n_ack++;
        end
        if (rst_n && bus.rsp_valid != '0) begin
            mon_v = '0;
            mon_d = '0;
            if (rsp_q.size() > 0) begin
                mon_e = rsp_q.pop_front();
                mon_v = NREQ'(1) << mon_e.idx;
                mon_d = mon_e.data;
            end
            checks++;
            assert (bus.rsp_valid === mon_v) else begin
                errors++; $error("FAIL rsp_idx got %b exp %b", bus.rsp_valid, mon_v);
            end
            checks++;
            assert (bus.rsp_out === mon_d) else begin
                errors++; $error("FAIL rsp_data got %h exp %h", bus.rsp_out, mon_d);
            end
            n_rsp++;
        end
        if (rst_n && bus.req_ack != '0 && bus.rsp_valid != '0) begin
            checks++;
            assert (bus.req_ack === bus.rsp_valid) else begin
                errors++; $error("FAIL ack_rsp_clash got %b exp %b", bus.req_ack, bus.rsp_valid);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_rsp(input int idx, input logic [63:0] d);
        rsp_t e;
        e.idx  = idx;
        e.data = d;
        rsp_q.push_back(e);
    endtask

    task automatic set_req(input logic [1:0] i, input logic [2:0] op, input real a, input real b);
        bus.req_op[i]    = op;
        bus.req_rmode[i] = 2'(i);
        bus.req_opa[i]   = $realtobits(a);
        bus.req_opb[i]   = $realtobits(b);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic wait_ack(input logic [1:0] i);
        int t = 0;
        while (bus.req_ack[i] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("ack_wait", {63'd0, bus.req_ack[i]}, 64'd1);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_n_ack(input int target);
        int t = 0;
        while (n_ack < target && t < 200) begin @(negedge clk); t++; end
        chk("ack_count", 64'(n_ack), 64'(target));
    endtask

    task automatic wait_n_rsp(input int target);
        int t = 0;
        while (n_rsp < target && t < 200) begin @(negedge clk); t++; end
        chk("rsp_count", 64'(n_rsp), 64'(target));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_en"},   {63'd0, fpu_enable}, 64'd0);
        chk({tag, "_ack"},  64'(bus.req_ack), 64'd0);
        chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp"},  bus.rsp_out, 64'd0);
        chk({tag, "_opa"},  fpu_opa, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_rmode = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: exact latency of ack, held enable, response timing.
        ack_q.push_back(0);
        push_rsp(0, 64'h4008000000000000);
        bus.req_op[0] = 3'b000; bus.req_rmode[0] = 2'b01;
        bus.req_opa[0] = 64'h3FF0000000000000; bus.req_opb[0] = 64'h4000000000000000;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ack", 64'(bus.req_ack), 64'h1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_op", 64'(fpu_op), 64'd0);
        chk("t1_rmode", 64'(fpu_rmode), 64'd1);
        chk("t1_opb", fpu_opb, 64'h4000000000000000);
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t1_en_held", {63'd0, fpu_enable}, 64'd1);
            chk("t1_opa_held", fpu_opa, 64'h3FF0000000000000);
        end
        @(negedge clk);
        chk("t1_rspv", 64'(bus.rsp_valid), 64'h1);
        chk("t1_rsp", bus.rsp_out, 64'h4008000000000000);
        chk("t1_en_low", {63'd0, fpu_enable}, 64'd0);
        @(negedge clk);
        chk("t1_rspv_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("t1_rsp_hold", bus.rsp_out, 64'h4008000000000000);
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // All four held high from reset: order 0,1,2,3,0.
        rst_n = 1'b0;
        set_req(0, 3'b000, 1.0, 2.0);
        set_req(1, 3'b010, 2.0, 2.0);
        set_req(2, 3'b000, 3.0, 2.0);
        set_req(3, 3'b010, 4.0, 2.0);
        foreach (ack_q[i]) ack_q.delete(i);
        ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(2);
        ack_q.push_back(3); ack_q.push_back(0);
        push_rsp(0, $realtobits(3.0)); push_rsp(1, $realtobits(4.0));
        push_rsp(2, $realtobits(5.0)); push_rsp(3, $realtobits(8.0));
        push_rsp(0, $realtobits(3.0));
        @(negedge clk);
        rst_n = 1'b1;
        wait_n_ack(n_ack + 5);
        bus.req_valid = '0;
        wait_n_rsp(6);

        // Requester 2 arrives while 0 is in flight and is served next.
        ack_q.push_back(0); push_rsp(0, $realtobits(6.0));
        ack_q.push_back(2); push_rsp(2, 64'h4018000000000000);
        @(negedge clk);
        set_req(0, 3'b000, 5.0, 1.0);
        wait_ack(0);
        bus.req_op[2] = 3'b010;
        bus.req_opa[2] = 64'h4000000000000000; bus.req_opb[2] = 64'h4008000000000000;
        bus.req_valid[2] = 1'b1;
        wait_ack(2);
        wait_n_rsp(8);

        // A one-cycle pulse on requester 1 during S_RUN is withdrawn.
        ack_q.push_back(0); push_rsp(0, $realtobits(2.0));
        @(negedge clk);
        set_req(0, 3'b000, 1.0, 1.0);
        wait_ack(0);
        @(negedge clk);
        bus.req_valid[1] = 1'b1;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_n_rsp(9);
        repeat (10) @(negedge clk);
        chk("t4_no_grant", 64'(n_ack), 64'd9);

        // Reset mid-operation: immediate zero outputs, no stale response, pointer back to 0.
        ack_q.push_back(1);
        set_req(1, 3'b000, 7.0, 1.0);
        wait_ack(1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_no_stale", 64'(n_rsp), 64'd9);
        ack_q.push_back(1); push_rsp(1, $realtobits(4.0));
        ack_q.push_back(3); push_rsp(3, $realtobits(6.0));
        set_req(1, 3'b000, 1.5, 2.5);
        set_req(3, 3'b010, 1.5, 4.0);
        wait_ack(1);
        wait_ack(3);
        wait_n_rsp(11);

`ifdef FPU_ARB_FLAGS_EN
        begin
            int t = 0;
            ack_q.push_back(0); push_rsp(0, 64'h7FF0000000000000);
            @(negedge clk);
            bus.req_op[0] = 3'b011;
            bus.req_opa[0] = 64'h3FF0000000000000; bus.req_opb[0] = 64'd0;
            bus.req_valid[0] = 1'b1;
            wait_ack(0);
            while (bus.rsp_valid[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            chk("flags_div0", 64'(rsp_flags), 64'h08);
        end
`endif

        repeat (5) @(negedge clk);
        chk("sb_rsp_empty", 64'(rsp_q.size()), 64'd0);
        chk("sb_ack_empty", 64'(ack_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
